// File: rtl/lib_fifo_sched.sv
// Round-robin scheduler draining up to N head-of-FIFO words into one registered
// output stage, granting each requester a burst of at most BURST words.
module lib_fifo_sched #(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int BURST = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N*WIDTH-1:0] i_data,
  input  logic [N-1:0]       i_data_val,
  output logic [N-1:0]       o_fifo_en,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_data_val,
  input  logic               i_en,
  output logic [N-1:0]       o_grant
);

  localparam int                IW       = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned       NU       = N;
  localparam logic [3:0]        CNT_LAST = 4'(BURST - 1);
  localparam logic [IW-1:0]     LAST_RST = IW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IW-1:0]    r_g;
  logic [IW-1:0]    r_last;
  logic [3:0]       r_cnt;
  logic [N-1:0]     r_grant;
  logic [WIDTH-1:0] r_data;
  logic             r_data_val;

  logic [IW-1:0]    w_pick;
  logic [IW-1:0]    w_idx;
  logic             w_found;
  logic [N-1:0]     w_pick_oh;
  logic             w_gval;
  logic             w_load;
  logic             w_enter;
  logic             w_release;

  // First valid requester scanning upward from last+1, wrapping modulo N.
  always_comb begin
    w_pick  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int unsigned i = 1; i <= NU; i++) begin
      w_idx = IW'((32'(r_last) + i) % NU);
      if (!w_found && i_data_val[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_pick_oh = {{(N-1){1'b0}}, 1'b1} << w_pick;
  assign w_gval    = i_data_val[r_g];
  assign w_load    = reset_n && (r_state == GRANT) && w_gval && (!r_data_val || i_en);
  assign w_enter   = (r_state == IDLE)  && (w_state_nxt == GRANT);
  assign w_release = (r_state == GRANT) && (w_state_nxt == IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A stalled grant (valid head, output full, no i_en) holds in GRANT.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (|i_data_val) begin
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        if ((w_load && (r_cnt == CNT_LAST)) || !w_gval) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_fifo_en = '0;
    if (w_load) begin
      o_fifo_en[r_g] = 1'b1;
    end
    o_grant    = r_grant;
    o_data     = r_data;
    o_data_val = r_data_val;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_g     <= '0;
      r_cnt   <= '0;
      r_last  <= LAST_RST;
      r_grant <= '0;
    end else begin
      if (w_enter) begin
        r_g     <= w_pick;
        r_cnt   <= '0;
        r_grant <= w_pick_oh;
      end else if (w_load) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_release) begin
        r_last  <= r_g;
        r_grant <= '0;
      end
    end
  end

  // A load and a downstream consume may coincide; the load wins and valid stays set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data     <= '0;
      r_data_val <= 1'b0;
    end else if (w_load) begin
      r_data     <= i_data[r_g*WIDTH +: WIDTH];
      r_data_val <= 1'b1;
    end else if (i_en) begin
      r_data_val <= 1'b0;
    end
  end

  a_fifo_en_onehot0 : assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(o_fifo_en));
  a_grant_onehot0   : assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(r_grant));
  a_en_within_grant : assert property (@(posedge clk) disable iff (!reset_n)
    ((o_fifo_en & ~r_grant) == '0));

endmodule
